// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants, helper functions and engine state type.
// Used by the compression engine and by the schedule-expansion stage.
package sha256_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned NUM_WORDS  = 8;
  localparam int unsigned NUM_ROUNDS = 64;
  localparam int unsigned ROUND_W    = 6;
  localparam int unsigned SCHED_W    = WORD_W * NUM_ROUNDS;
  localparam int unsigned HASH_W     = WORD_W * NUM_WORDS;
  localparam int unsigned SCHED_IW   = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Working variables; a sits in the MSBs to match the hash word order.
  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] c;
    logic [WORD_W-1:0] d;
    logic [WORD_W-1:0] e;
    logic [WORD_W-1:0] f;
    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] h;
  } work_t;

  localparam logic [WORD_W-1:0] K [NUM_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [HASH_W-1:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Rotate right via a doubled word so no negative shift is ever formed.
  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    logic [2*WORD_W-1:0] w_dbl;
    w_dbl = {x, x} >> n;
    return w_dbl[WORD_W-1:0];
  endfunction

  function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] e, input logic [WORD_W-1:0] f,
                                           input logic [WORD_W-1:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b,
                                            input logic [WORD_W-1:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 round.
// Ports:
//   i_work  in  256  working variables a..h (a in MSBs)
//   i_wt    in  32   schedule word W[t]
//   i_kt    in  32   round constant K[t]
//   o_work  out 256  working variables after the round
module sha256_round
  import sha256_pkg::*;
(
  input  logic [HASH_W-1:0] i_work,
  input  logic [WORD_W-1:0] i_wt,
  input  logic [WORD_W-1:0] i_kt,
  output logic [HASH_W-1:0] o_work
);

  work_t             w_in;
  work_t             w_out;
  logic [WORD_W-1:0] w_t1;
  logic [WORD_W-1:0] w_t2;

  assign w_in   = work_t'(i_work);
  assign o_work = HASH_W'(w_out);

  // Round function; all sums wrap modulo 2^32.
  always_comb begin
    w_t1    = w_in.h + big_sigma1(w_in.e) + ch(w_in.e, w_in.f, w_in.g) + i_kt + i_wt;
    w_t2    = big_sigma0(w_in.a) + maj(w_in.a, w_in.b, w_in.c);
    w_out.a = w_t1 + w_t2;
    w_out.b = w_in.a;
    w_out.c = w_in.b;
    w_out.d = w_in.c;
    w_out.e = w_in.d + w_t1;
    w_out.f = w_in.e;
    w_out.g = w_in.f;
    w_out.h = w_in.g;
  end

endmodule

// File: rtl/sha256_compress.sv
// sha256_compress: 64-round SHA-256 compression, one round per clock,
// with the final feed-forward add into the chaining state.
// Ports:
//   clk        in   1     rising-edge clock
//   rst        in   1     asynchronous active-high reset
//   in_valid   in   1     schedule/hash_in valid
//   in_ready   out  1     engine idle, job accepted on in_valid & in_ready
//   schedule   in   2048  W0 in [2047:2016] ... W63 in [31:0]
//   hash_in    in   256   chaining state H0 in [255:224] ... H7 in [31:0]
//   out_valid  out  1     hash_out holds a completed result
//   out_ready  in   1     consumer takes the result
//   hash_out   out  256   new chaining state
module sha256_compress
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SCHED_W-1:0] schedule,
  input  logic [HASH_W-1:0]  hash_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [HASH_W-1:0]  hash_out
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ROUND_W-1:0]  r_t;
  logic [SCHED_W-1:0]  r_sched;
  logic [HASH_W-1:0]   r_hin;
  logic [HASH_W-1:0]   r_work;
  logic [HASH_W-1:0]   r_hash_out;
  logic                r_out_valid;

  logic                w_accept;
  logic                w_round_en;
  logic                w_final;
  logic                w_retire;
  logic [WORD_W-1:0]   w_wt;
  logic [WORD_W-1:0]   w_kt;
  logic [HASH_W-1:0]   w_work_nxt;
  logic [HASH_W-1:0]   w_sum;
  logic [SCHED_IW-1:0] w_wt_msb;

  // W[t] is read in place from the captured schedule; nothing shifts.
  assign w_wt_msb = SCHED_IW'(SCHED_W - 1) - {r_t, 5'd0};
  assign w_wt     = r_sched[w_wt_msb -: WORD_W];
  assign w_kt     = K[r_t];

  sha256_round u_round (
    .i_work (r_work),
    .i_wt   (w_wt),
    .i_kt   (w_kt),
    .o_work (w_work_nxt)
  );

  // Feed-forward: per-word add of the working variables into the captured chain.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < int'(NUM_WORDS); i++) begin
      w_sum[i*WORD_W +: WORD_W] = r_hin[i*WORD_W +: WORD_W] + r_work[i*WORD_W +: WORD_W];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_round_en  = 1'b0;
    w_final     = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ROUND;
        end
      end
      ST_ROUND: begin
        w_round_en = 1'b1;
        if (r_t == ROUND_W'(NUM_ROUNDS - 1)) w_state_nxt = ST_FINAL;
      end
      ST_FINAL: begin
        w_final     = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          w_retire    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t         <= '0;
      r_sched     <= '0;
      r_hin       <= '0;
      r_work      <= '0;
      r_hash_out  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sched <= schedule;
        r_hin   <= hash_in;
        r_work  <= hash_in;
        r_t     <= '0;
      end
      if (w_round_en) begin
        r_work <= w_work_nxt;
        r_t    <= r_t + ROUND_W'(1);
      end
      if (w_final) begin
        r_hash_out  <= w_sum;
        r_out_valid <= 1'b1;
      end
      if (w_retire) r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign hash_out  = r_hash_out;

endmodule

// File: tb/tb_sha256_compress.sv
// tb_sha256_compress: directed and randomized checks of the SHA-256 compression engine.
module tb_sha256_compress;
  import sha256_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2047:0] schedule = '0;
  logic [255:0] hash_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] hash_out;

  int n_checks = 0;
  int n_pass   = 0;

  sha256_compress dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .schedule  (schedule),
    .hash_in   (hash_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hash_out  (hash_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [2047:0] expand(input logic [511:0] blk);
    logic [31:0]   w [64];
    logic [2047:0] s;
    logic [31:0]   s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0   = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1   = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    s = '0;
    for (int t = 0; t < 64; t++) s[2047 - 32*t -: 32] = w[t];
    return s;
  endfunction

  function automatic logic [255:0] model(input logic [2047:0] s, input logic [255:0] hin);
    logic [31:0]  v [8];
    logic [31:0]  t1, t2, e, a;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      e  = v[4];
      a  = v[0];
      t1 = v[7] + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & v[5]) ^ (~e & v[6]))
           + K[t] + s[2047 - 32*t -: 32];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & v[1]) ^ (a & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [255:0] byte_rev(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255 - 8*i -: 8];
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic scramble_inputs();
    for (int i = 0; i < 64; i++) schedule[32*i +: 32] = $urandom;
    for (int i = 0; i < 8; i++)  hash_in[32*i +: 32]  = $urandom;
  endtask

  // Presents a job and holds it across one edge; leaves us 1ns after the accept edge.
  task automatic start_job(input logic [2047:0] s, input logic [255:0] h);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_accept", 256'(in_ready), 256'd1);
    in_valid = 1'b1;
    schedule = s;
    hash_in  = h;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();
  endtask

  // Counts edges after accept until out_valid is seen, bounded.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic do_job(input string tag, input logic [2047:0] s, input logic [255:0] h,
                        input logic [255:0] exp, input bit rdy_early, output logic [255:0] got);
    int lat;
    int stall;
    out_ready = rdy_early;
    start_job(s, h);
    wait_result(lat);
    check({tag, "_latency"}, 256'(lat), 256'd65);
    got = hash_out;
    check(tag, hash_out, exp);
    if (!rdy_early) begin
      stall = int'($urandom_range(0, 3));
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check({tag, "_stall_hold"}, hash_out, exp);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_retired"}, 256'(out_valid), 256'd0);
    check({tag, "_idle"}, 256'(in_ready), 256'd1);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [255:0] ABC_EXP =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_EXP =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] GENESIS_REV =
    256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;

  initial begin
    logic [511:0]  blk_abc, blk_empty, c1, c2, c3;
    logic [2047:0] s_abc, s_empty, s_rnd;
    logic [255:0]  got, h1m, h2m, h_rnd;
    int            lat;

    blk_abc   = {32'h61626380, 448'h0, 32'h00000018};
    blk_empty = {32'h80000000, 480'h0};
    s_abc     = expand(blk_abc);
    s_empty   = expand(blk_empty);

    // Reset values.
    #12;
    check("rst_in_ready", 256'(in_ready), 256'd1);
    check("rst_out_valid", 256'(out_valid), 256'd0);
    check("rst_hash_out", hash_out, 256'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-block known answers.
    do_job("abc", s_abc, IV, ABC_EXP, 1'b1, got);
    do_job("empty", s_empty, IV, EMPTY_EXP, 1'b0, got);

    // Back-pressure with an extra job offered while the result waits.
    out_ready = 1'b0;
    start_job(s_empty, IV);
    wait_result(lat);
    check("bp_latency", 256'(lat), 256'd65);
    check("bp_first", hash_out, EMPTY_EXP);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        in_valid = 1'b1;
        schedule = s_abc;
        hash_in  = IV;
      end
      if (c == 8) in_valid = 1'b0;
      @(posedge clk); #1;
      check("bp_hash_hold", hash_out, EMPTY_EXP);
      check("bp_valid_hold", 256'(out_valid), 256'd1);
      check("bp_in_ready", 256'(in_ready), 256'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_released_idle", 256'(in_ready), 256'd1);
    check("bp_released_valid", 256'(out_valid), 256'd0);
    @(posedge clk); #1;
    check("bp_second_not_started", 256'(in_ready), 256'd1);
    do_job("bp_second", s_abc, IV, ABC_EXP, 1'b0, got);

    // Asynchronous reset at round 30.
    out_ready = 1'b0;
    start_job(s_abc, IV);
    repeat (30) begin @(posedge clk); #1; end
    check("mid_busy", 256'(in_ready), 256'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 256'(in_ready), 256'd1);
    check("mid_rst_out_valid", 256'(out_valid), 256'd0);
    check("mid_rst_hash_out", hash_out, 256'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_no_output", 256'(out_valid), 256'd0);
    do_job("post_rst_abc", s_abc, IV, ABC_EXP, 1'b1, got);

    // Bitcoin genesis header double SHA-256.
    c1 = {32'h01000000, 256'h0, 32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61,
          32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa};
    c2 = {32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c, 32'h80000000, 320'h0,
          32'h00000280};
    h1m = model(expand(c1), IV);
    do_job("genesis_c1", expand(c1), IV, h1m, 1'b1, got);
    h2m = model(expand(c2), h1m);
    do_job("genesis_c2", expand(c2), h1m, h2m, 1'b0, got);
    c3 = {h2m, 32'h80000000, 192'h0, 32'h00000100};
    do_job("genesis_final", expand(c3), IV, byte_rev(GENESIS_REV), 1'b1, got);
    check("genesis_reversed", byte_rev(got), GENESIS_REV);

    // Randomized back-to-back jobs with random consumer stalls.
    for (int j = 0; j < 200; j++) begin
      for (int i = 0; i < 64; i++) s_rnd[32*i +: 32] = $urandom;
      for (int i = 0; i < 8; i++)  h_rnd[32*i +: 32] = $urandom;
      do_job($sformatf("rnd%0d", j), s_rnd, h_rnd, model(s_rnd, h_rnd),
             1'($urandom_range(0, 1)), got);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sha256_compress.md
# sha256_compress

SHA-256 compression engine that consumes a fully expanded 64-word message schedule (W0..W63) from the schedule-expansion stage, together with a 256-bit chaining state. It runs the 64 SHA-256 rounds at one round per clock and adds the result back into the chaining state. It produces the next 256-bit hash state. It sits directly downstream of the block-fill/schedule stage in the Bitcoin double-SHA-256 datapath.

## Interface
- No parameters. Round constants and IV are fixed and live in the shared package.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  schedule and hash_in are valid this cycle.
- in_ready  out  1  engine idle; `in_valid & in_ready` at a rising edge accepts a job.
- schedule  in  2048  W0 in [2047:2016], Wt in [2047-32t -: 32]; all 64 words must be defined.
- hash_in  in  256  chaining state, H0 (a) in [255:224] … H7 (h) in [31:0].
- out_valid  out  1  hash_out holds a completed result.
- out_ready  in  1  consumer takes the result; `out_valid & out_ready` at a rising edge retires it.
- hash_out  out  256  new state, same word order as hash_in.

## Operation
- States:
  - IDLE: in_ready=1.
  - ROUND: t = 0..63.
  - FINAL: adds the working variables back into the chaining state.
  - DONE: out_valid=1.
- IDLE→ROUND on accept.
  - Capture schedule and hash_in into internal registers.
  - Load a..h from hash_in.
  - Set t=0.
- ROUND, each edge:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t].
  - T2 = Σ0(a) + Maj(a,b,c).
  - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - t←t+1.
  - At t=63, go to FINAL.
- Arithmetic rules:
  - All additions are 32-bit modulo 2^32; carries are discarded.
  - Σ0 = ROTR2^ROTR13^ROTR22.
  - Σ1 = ROTR6^ROTR11^ROTR25.
  - Ch = (e&f)^(~e&g).
  - Maj = (a&b)^(a&c)^(b&c).
- FINAL: hash_out[i] ← H_in[i] + working[i] (mod 2^32) for all 8 words; out_valid←1; go to DONE.
- DONE: hold hash_out and out_valid stable until out_ready=1, then go to IDLE with out_valid←0. hash_out keeps its last value.
- in_ready = (state==IDLE), decoded from registered state. in_valid outside IDLE is ignored.
- Input ports may change freely after the accept edge; only the captured copies are used.
- Reset values: state=IDLE, in_ready=1, out_valid=0, hash_out=0, t=0, a..h=0.
- Reset mid-operation aborts the job with no output. The first accept after rst deasserts starts cleanly.

## Timing
- Accept edge T; rounds execute on edges T+1..T+64; FINAL on edge T+65.
- out_valid is high after edge T+65. Latency is 65 clocks from accept to result.
- If out_ready is already high when out_valid rises, the result retires on edge T+66. The next accept is possible on edge T+67 at the earliest.
- Throughput is therefore one job per 67 cycles with an always-ready consumer.
- Back-pressure: out_valid stays high indefinitely while out_ready=0. No job is lost or overwritten.
- No combinational path from in_valid or out_ready to any output.

## Structure
- Package sha256_pkg holds:
  - K[0:63] constant array.
  - IV constant: 6a09e667 … 5be0cd19.
  - Functions big_sigma0, big_sigma1, ch, maj.
  - State enum for IDLE/ROUND/FINAL/DONE.
- The schedule stage shares the same package for its small sigma0/sigma1.
- One sub-module: sha256_round. It is combinational: (a..h, Wt, Kt) in, next a..h out. It is instantiated once, and the FSM wraps it.
- Schedule storage is a 2048-bit register indexed by t. It is not shifted.

## Test plan
- "abc" single block: schedule from the bench model of the padded block 61626380 00…0018, hash_in=IV → hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, out_valid exactly 65 cycles after accept.
- Empty message (block 80000000 0…0), hash_in=IV → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid; pulse in_valid with a different job during that window.
  - Required: hash_out stable; in_ready=0; second job ignored.
  - After release: IDLE, then the second job is accepted and correct.
- Reset at round 30 of a job:
  - Required: all outputs return to reset values asynchronously.
  - A new "abc" job afterwards yields the correct digest.
- Bitcoin genesis header double hash:
  - Chunk 1 from IV, chunk 2 chained from the chunk 1 result, then a second SHA over that 256-bit digest.
  - Required: byte-reversed result = 000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f.
- Randomized back-to-back jobs (≥200) with random out_ready stalls and input changes after accept → every result matches the software model, in order.
